// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer
//  Purpose  : Fetches 10-bit instructions over a valid/ready handshake into an
//             internal IR, steps timestep T and drives the per-step datapath
//             controls (register file, ALU A/G registers, bus drivers).
//  Ports    : clk, resetn        - clock, synchronous active-low reset
//             run                - permits new fetches (looked at only in T0)
//             ext_data/valid     - external bus word and its valid flag
//             ext_ready          - sequencer consumes ext_data this cycle
//             T, IR              - current timestep, latched instruction
//             Rin/Rout/ENW/ENR   - register-file write/read address + enable
//             Ain/Gin/Gout       - ALU register load / G bus drive
//             ALUcont            - ALU operation code
//             Ext, IRin          - external bus drive, IR load strobe
//             done, illegal      - end of legal instruction / illegal pulse
//             retired            - completed legal instruction count
//  Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
    parameter int         CNT_W    = 16,
    parameter logic [3:0] FUNC_MAX = 4'b1011
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run,
    input  logic [9:0]       ext_data,
    input  logic             ext_valid,
    output logic             ext_ready,
    output logic [1:0]       T,
    output logic [9:0]       IR,
    output logic [1:0]       Rin,
    output logic [1:0]       Rout,
    output logic             ENW,
    output logic             ENR,
    output logic             Ain,
    output logic             Gin,
    output logic             Gout,
    output logic [3:0]       ALUcont,
    output logic             Ext,
    output logic             IRin,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        S_T0 = 2'd0,
        S_T1 = 2'd1,
        S_T2 = 2'd2,
        S_T3 = 2'd3
    } step_e;

    localparam logic [3:0] c_FUNC_LOAD = 4'b0000;
    localparam logic [3:0] c_FUNC_COPY = 4'b0001;
    localparam logic [3:0] c_FUNC_INV  = 4'b0100;
    localparam logic [3:0] c_FUNC_FLIP = 4'b0101;

    step_e            r_t;
    step_e            w_t_next;
    logic [9:0]       r_ir;
    logic [CNT_W-1:0] r_retired;

    logic [1:0] w_rx;
    logic [1:0] w_ry;
    logic [3:0] w_func;
    logic       w_legal;
    logic       w_unary;

    assign w_rx    = r_ir[7:6];
    assign w_ry    = r_ir[5:4];
    assign w_func  = r_ir[3:0];
    assign w_legal = (r_ir[9:8] == 2'b00) && (w_func <= FUNC_MAX);
    assign w_unary = (w_func == c_FUNC_INV) || (w_func == c_FUNC_FLIP);

    // State register: reset aborts any instruction in flight with no write-back.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_t       <= S_T0;
            r_ir      <= 10'd0;
            r_retired <= '0;
        end else begin
            r_t <= w_t_next;
            if (IRin) begin
                r_ir <= ext_data;
            end
            if (done) begin
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next step and control decode. Everything is held at zero while reset is
    // asserted so nothing is fetched or written during reset.
    always_comb begin
        w_t_next  = r_t;
        ext_ready = 1'b0;
        Ext       = 1'b0;
        IRin      = 1'b0;
        Rin       = 2'd0;
        Rout      = 2'd0;
        ENW       = 1'b0;
        ENR       = 1'b0;
        Ain       = 1'b0;
        Gin       = 1'b0;
        Gout      = 1'b0;
        ALUcont   = 4'd0;
        done      = 1'b0;
        illegal   = 1'b0;
        if (resetn) begin
            case (r_t)
                S_T0: begin
                    ext_ready = run;
                    Ext       = run;
                    IRin      = run & ext_valid;
                    if (run && ext_valid) begin
                        w_t_next = S_T1;
                    end
                end
                S_T1: begin
                    if (!w_legal) begin
                        illegal  = 1'b1;
                        w_t_next = S_T0;
                    end else if (w_func == c_FUNC_LOAD) begin
                        // Stall here until the immediate arrives.
                        ext_ready = 1'b1;
                        Ext       = 1'b1;
                        Rin       = w_rx;
                        ENW       = ext_valid;
                        if (ext_valid) begin
                            done     = 1'b1;
                            w_t_next = S_T0;
                        end
                    end else if (w_func == c_FUNC_COPY) begin
                        Rout     = w_ry;
                        Rin      = w_rx;
                        ENR      = 1'b1;
                        ENW      = 1'b1;
                        done     = 1'b1;
                        w_t_next = S_T0;
                    end else if (w_unary) begin
                        Rout     = w_ry;
                        ENR      = 1'b1;
                        Gin      = 1'b1;
                        ALUcont  = w_func;
                        w_t_next = S_T2;
                    end else begin
                        Rout     = w_rx;
                        ENR      = 1'b1;
                        Ain      = 1'b1;
                        w_t_next = S_T2;
                    end
                end
                S_T2: begin
                    if (w_unary) begin
                        Rin      = w_rx;
                        ENW      = 1'b1;
                        Gout     = 1'b1;
                        done     = 1'b1;
                        w_t_next = S_T0;
                    end else begin
                        Rout     = w_ry;
                        ENR      = 1'b1;
                        Gin      = 1'b1;
                        ALUcont  = w_func;
                        w_t_next = S_T3;
                    end
                end
                default: begin
                    Rin      = w_rx;
                    ENW      = 1'b1;
                    Gout     = 1'b1;
                    done     = 1'b1;
                    w_t_next = S_T0;
                end
            endcase
        end
    end

    assign T       = r_t;
    assign IR      = r_ir;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_sequencer
//  Purpose  : Directed self-checking bench for instr_sequencer. A second
//             instance with a 4-bit retired counter shares the stimulus so the
//             counter wrap can be reached in a short run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       run;
    logic [9:0] ext_data;
    logic       ext_valid;

    logic        ext_ready, ENW, ENR, Ain, Gin, Gout, Ext, IRin, done, illegal;
    logic [1:0]  T, Rin, Rout;
    logic [9:0]  IR;
    logic [3:0]  ALUcont;
    logic [15:0] retired;

    logic        w_ext_ready, w_ENW, w_ENR, w_Ain, w_Gin, w_Gout, w_Ext, w_IRin, w_done, w_illegal;
    logic [1:0]  w_T, w_Rin, w_Rout;
    logic [9:0]  w_IR;
    logic [3:0]  w_ALUcont;
    logic [3:0]  w_retired;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .resetn(resetn), .run(run), .ext_data(ext_data), .ext_valid(ext_valid),
        .ext_ready(ext_ready), .T(T), .IR(IR), .Rin(Rin), .Rout(Rout), .ENW(ENW), .ENR(ENR),
        .Ain(Ain), .Gin(Gin), .Gout(Gout), .ALUcont(ALUcont), .Ext(Ext), .IRin(IRin),
        .done(done), .illegal(illegal), .retired(retired)
    );

    instr_sequencer #(.CNT_W(4)) dut_w (
        .clk(clk), .resetn(resetn), .run(run), .ext_data(ext_data), .ext_valid(ext_valid),
        .ext_ready(w_ext_ready), .T(w_T), .IR(w_IR), .Rin(w_Rin), .Rout(w_Rout), .ENW(w_ENW),
        .ENR(w_ENR), .Ain(w_Ain), .Gin(w_Gin), .Gout(w_Gout), .ALUcont(w_ALUcont), .Ext(w_Ext),
        .IRin(w_IRin), .done(w_done), .illegal(w_illegal), .retired(w_retired)
    );

    wire [17:0] ctl = {ext_ready, Ext, IRin, ENW, ENR, Ain, Gin, Gout, done, illegal, Rin, Rout, ALUcont};

    // Builds an expected control vector in the same field order as ctl.
    function automatic logic [17:0] ec(input logic rdy, input logic ext, input logic irin,
                                       input logic enw, input logic enr, input logic ain,
                                       input logic gin, input logic gout, input logic dn,
                                       input logic ill, input logic [1:0] rin,
                                       input logic [1:0] rout, input logic [3:0] alu);
        return {rdy, ext, irin, enw, enr, ain, gin, gout, dn, ill, rin, rout, alu};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] e;
        resetn = 1'b0; run = 1'b1; ext_valid = 1'b1; ext_data = 10'h3FF;
        tick(); tick(); #1;
        checks++; if (ctl !== 18'd0) begin errors++; $display("FAIL reset_ctl got %h want 0", ctl); end
        checks++; if (T !== 2'd0) begin errors++; $display("FAIL reset_T got %0d want 0", T); end
        checks++; if (IR !== 10'd0) begin errors++; $display("FAIL reset_IR got %h want 0", IR); end
        checks++; if (retired !== 16'd0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
        resetn = 1'b1; #1;
        e = ec(1,1,1,0,0,0,0,0,0,0,2'd0,2'd0,4'd0);
        checks++; if (ctl !== e) begin errors++; $display("FAIL first_fetch ctl got %h want %h", ctl, e); end
        tick(); run = 1'b0; ext_valid = 1'b0; #1;
        checks++; if (IR !== 10'h3FF || T !== 2'd1) begin errors++; $display("FAIL first_fetch_ir IR=%h T=%0d want 3ff/1", IR, T); end
        e = ec(0,0,0,0,0,0,0,0,0,1,2'd0,2'd0,4'd0);
        checks++; if (ctl !== e) begin errors++; $display("FAIL first_fetch_illegal ctl got %h want %h", ctl, e); end
        tick();
        checks++; if (T !== 2'd0 || ctl !== 18'd0 || retired !== 16'd0) begin errors++; $display("FAIL idle T=%0d ctl=%h ret=%0d want 0/0/0", T, ctl, retired); end
    endtask

    task automatic test_add();
        logic [17:0] e;
        run = 1'b1; ext_valid = 1'b1; ext_data = 10'h062; #1;
        checks++; if (IRin !== 1'b1) begin errors++; $display("FAIL add_fetch IRin got %b want 1", IRin); end
        tick(); run = 1'b0; ext_valid = 1'b0; #1;
        e = ec(0,0,0,0,1,1,0,0,0,0,2'd0,2'd1,4'd0);
        checks++; if (T !== 2'd1 || ctl !== e) begin errors++; $display("FAIL add_t1 T=%0d ctl=%h want 1/%h", T, ctl, e); end
        tick();
        e = ec(0,0,0,0,1,0,1,0,0,0,2'd0,2'd2,4'b0010);
        checks++; if (T !== 2'd2 || ctl !== e) begin errors++; $display("FAIL add_t2 T=%0d ctl=%h want 2/%h", T, ctl, e); end
        tick();
        e = ec(0,0,0,1,0,0,0,1,1,0,2'd1,2'd0,4'd0);
        checks++; if (T !== 2'd3 || ctl !== e) begin errors++; $display("FAIL add_t3 T=%0d ctl=%h want 3/%h", T, ctl, e); end
        tick();
        checks++; if (T !== 2'd0 || retired !== 16'd1) begin errors++; $display("FAIL add_end T=%0d ret=%0d want 0/1", T, retired); end
    endtask

    task automatic test_load_stall();
        logic [17:0] e;
        run = 1'b1; ext_valid = 1'b1; ext_data = 10'h0C0;
        tick(); run = 1'b0; ext_valid = 1'b0; #1;
        e = ec(1,1,0,0,0,0,0,0,0,0,2'd3,2'd0,4'd0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (T !== 2'd1 || ctl !== e) begin errors++; $display("FAIL load_stall%0d T=%0d ctl=%h want 1/%h", i, T, ctl, e); end
            if (i < 2) tick();
        end
        ext_data = 10'h155; ext_valid = 1'b1; #1;
        e = ec(1,1,0,1,0,0,0,0,1,0,2'd3,2'd0,4'd0);
        checks++; if (ctl !== e) begin errors++; $display("FAIL load_hs ctl got %h want %h", ctl, e); end
        tick(); ext_valid = 1'b0; #1;
        checks++; if (T !== 2'd0 || IR !== 10'h0C0 || retired !== 16'd2) begin errors++; $display("FAIL load_end T=%0d IR=%h ret=%0d want 0/0c0/2", T, IR, retired); end
    endtask

    task automatic test_illegal();
        logic [9:0]  ins [2];
        logic [17:0] e;
        ins[0] = 10'h100; ins[1] = 10'h00C;
        e = ec(0,0,0,0,0,0,0,0,0,1,2'd0,2'd0,4'd0);
        for (int i = 0; i < 2; i++) begin
            run = 1'b1; ext_valid = 1'b1; ext_data = ins[i];
            tick(); run = 1'b0; ext_valid = 1'b0; #1;
            checks++; if (T !== 2'd1 || ctl !== e) begin errors++; $display("FAIL illegal%0d T=%0d ctl=%h want 1/%h", i, T, ctl, e); end
            tick();
            checks++; if (T !== 2'd0 || retired !== 16'd2) begin errors++; $display("FAIL illegal%0d_end T=%0d ret=%0d want 0/2", i, T, retired); end
        end
    endtask

    task automatic test_flip_run_drop();
        logic [17:0] e;
        run = 1'b1; ext_valid = 1'b1; ext_data = 10'h035;
        tick(); run = 1'b0; ext_data = 10'h2AA; #1;
        e = ec(0,0,0,0,1,0,1,0,0,0,2'd0,2'd3,4'b0101);
        checks++; if (T !== 2'd1 || ctl !== e) begin errors++; $display("FAIL flip_t1 T=%0d ctl=%h want 1/%h", T, ctl, e); end
        tick();
        e = ec(0,0,0,1,0,0,0,1,1,0,2'd0,2'd0,4'd0);
        checks++; if (T !== 2'd2 || ctl !== e) begin errors++; $display("FAIL flip_t2 T=%0d ctl=%h want 2/%h", T, ctl, e); end
        tick();
        checks++; if (T !== 2'd0 || ctl !== 18'd0 || retired !== 16'd3) begin errors++; $display("FAIL flip_idle T=%0d ctl=%h ret=%0d want 0/0/3", T, ctl, retired); end
        tick();
        checks++; if (T !== 2'd0 || IR !== 10'h035 || ext_ready !== 1'b0) begin errors++; $display("FAIL flip_hold T=%0d IR=%h rdy=%b want 0/035/0", T, IR, ext_ready); end
        ext_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        run = 1'b1; ext_valid = 1'b1; ext_data = 10'h091;
        tick();
        e = ec(0,0,0,1,1,0,0,0,1,0,2'd2,2'd1,4'd0);
        checks++; if (T !== 2'd1 || ctl !== e) begin errors++; $display("FAIL copy_t1 T=%0d ctl=%h want 1/%h", T, ctl, e); end
        tick();
        checks++; if (T !== 2'd0 || IRin !== 1'b1 || retired !== 16'd4) begin errors++; $display("FAIL b2b_refetch T=%0d IRin=%b ret=%0d want 0/1/4", T, IRin, retired); end
        tick();
        checks++; if (T !== 2'd1 || done !== 1'b1) begin errors++; $display("FAIL b2b_t1 T=%0d done=%b want 1/1", T, done); end
        tick(); run = 1'b0; ext_valid = 1'b0; #1;
        checks++; if (T !== 2'd0 || retired !== 16'd5) begin errors++; $display("FAIL b2b_end T=%0d ret=%0d want 0/5", T, retired); end
    endtask

    task automatic test_wrap();
        resetn = 1'b0; run = 1'b0; ext_valid = 1'b0;
        tick();
        resetn = 1'b1; run = 1'b1; ext_valid = 1'b1; ext_data = 10'h091;
        for (int i = 0; i < 15; i++) begin
            tick(); tick();
        end
        checks++; if (w_retired !== 4'd15 || retired !== 16'd15) begin errors++; $display("FAIL wrap_pre small=%0d big=%0d want 15/15", w_retired, retired); end
        tick(); tick(); run = 1'b0; ext_valid = 1'b0; #1;
        checks++; if (w_retired !== 4'd0 || retired !== 16'd16) begin errors++; $display("FAIL wrap small=%0d big=%0d want 0/16", w_retired, retired); end
    endtask

    initial begin
        resetn = 1'b0; run = 1'b0; ext_valid = 1'b0; ext_data = 10'd0;
        test_reset();
        test_add();
        test_load_stall();
        test_illegal();
        test_flip_run_drop();
        test_back_to_back();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
